// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single main_memory port (registered 1-cycle read) between
//   NUM_REQ requesters using a valid/ready handshake. One request is accepted
//   per cycle, and the accepted requester receives a one-hot rsp_valid strobe
//   in the following cycle. Read data is broadcast to every requester.
//
//   Build option:
//     MEM_ARB_FIXED_PRIORITY_EN  defined   -> strict fixed priority, lowest
//                                             index wins. Higher indices may
//                                             starve while a lower index stays
//                                             valid.
//                                undefined -> round-robin arbitration starting
//                                             at the requester after the last
//                                             grant.
//
//   Ports
//     clk, reset          single clock, synchronous active-high reset
//     req_valid/ready     per-requester handshake (ready is one-hot or zero)
//     req_address         per-requester byte address, ADDR_BITS per slice
//     req_wr_data         per-requester write data, WORD_BITS per slice
//     req_wr_en           per-requester byte mask, all-zero means read
//     rsp_valid           one-hot completion strobe, one cycle after accept
//     rsp_rd_data         read data (valid with rsp_valid for reads)
//     mem_*               connections to the memory port_x_* pins
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter  int NUM_REQ        = 2,
  parameter  int CAPACITY_BYTES = 128,
  parameter  int BYTES_PER_WORD = 4,
  localparam int WORD_BITS      = BYTES_PER_WORD * 8,
  localparam int ADDR_BITS      = $clog2(CAPACITY_BYTES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]       req_address,
  input  logic [NUM_REQ*WORD_BITS-1:0]       req_wr_data,
  input  logic [NUM_REQ*BYTES_PER_WORD-1:0]  req_wr_en,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [WORD_BITS-1:0]               rsp_rd_data,
  output logic                               mem_reset,
  output logic [ADDR_BITS-1:0]               mem_address,
  output logic                               mem_rd_en,
  output logic [WORD_BITS-1:0]               mem_wr_data,
  output logic [BYTES_PER_WORD-1:0]          mem_wr_en,
  input  logic [WORD_BITS-1:0]               mem_rd_data
);

  localparam int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_BITS-1:0]       ptr_eff_s;
  logic                      grant_vld_s;
  logic [PTR_BITS-1:0]       grant_idx_s;
  logic [BYTES_PER_WORD-1:0] sel_wr_en_s;
  logic [NUM_REQ-1:0]        rsp_valid_d;
  logic [NUM_REQ-1:0]        rsp_valid_q;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the search always starts at requester 0, no pointer state.
  assign ptr_eff_s = {PTR_BITS{1'b0}};
`else
  localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(NUM_REQ - 1);
  localparam logic [PTR_BITS-1:0] ONE_IDX  = PTR_BITS'(1);

  logic [PTR_BITS-1:0] ptr_d;
  logic [PTR_BITS-1:0] ptr_q;

  assign ptr_eff_s = ptr_q;

  // Round-robin pointer: move past the granted requester, hold when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld_s) begin
      ptr_d = (grant_idx_s == LAST_IDX) ? {PTR_BITS{1'b0}} : (grant_idx_s + ONE_IDX);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= {PTR_BITS{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Grant search: first pass covers ptr..NUM_REQ-1, second pass wraps to
  // 0..ptr-1. Reset blocks any acceptance in the same cycle.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {PTR_BITS{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld_s && req_valid[i] && (i >= int'(ptr_eff_s))) begin
        grant_vld_s = 1'b1;
        grant_idx_s = PTR_BITS'(i);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld_s && req_valid[i]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = PTR_BITS'(i);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    if (reset) begin
      grant_vld_s = 1'b0;
    end else begin
      grant_vld_s = grant_vld_s;
    end
  end

  // Handshake and memory-port drive: the winner's payload goes straight to
  // the memory, which samples it at the end of the accept cycle.
  always_comb begin
    req_ready   = {NUM_REQ{1'b0}};
    mem_address = {ADDR_BITS{1'b0}};
    mem_wr_data = {WORD_BITS{1'b0}};
    mem_wr_en   = {BYTES_PER_WORD{1'b0}};
    mem_rd_en   = 1'b0;
    sel_wr_en_s = req_wr_en[grant_idx_s*BYTES_PER_WORD +: BYTES_PER_WORD];
    if (grant_vld_s) begin
      req_ready   = NUM_REQ'(1) << grant_idx_s;
      mem_address = req_address[grant_idx_s*ADDR_BITS +: ADDR_BITS];
      mem_wr_data = req_wr_data[grant_idx_s*WORD_BITS +: WORD_BITS];
      mem_wr_en   = sel_wr_en_s;
      mem_rd_en   = ~|sel_wr_en_s;
    end else begin
      req_ready   = {NUM_REQ{1'b0}};
    end
  end

  // The response strobe is simply the accept vector delayed by one cycle.
  always_comb begin
    rsp_valid_d = req_ready;
  end

  // Response strobe register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= {NUM_REQ{1'b0}};
    end else begin
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // A reset in the response cycle kills the strobe of the request accepted
  // just before it, and the memory output register clears in that same cycle.
  assign rsp_valid   = reset ? {NUM_REQ{1'b0}} : rsp_valid_q;
  assign rsp_rd_data = mem_rd_data;
  assign mem_reset   = reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle memory.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AB = 7;
  localparam int WB = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AB-1:0] req_address;
  logic [NR*WB-1:0] req_wr_data;
  logic [NR*BW-1:0] req_wr_en;
  logic [NR-1:0]   rsp_valid;
  logic [WB-1:0]   rsp_rd_data;
  logic            mem_reset;
  logic [AB-1:0]   mem_address;
  logic            mem_rd_en;
  logic [WB-1:0]   mem_wr_data;
  logic [BW-1:0]   mem_wr_en;
  logic [WB-1:0]   mem_rd_data;

  // behavioural main_memory plus a bench-only preload port
  logic [WB-1:0]   mem [0:31];
  logic            pre_we;
  logic [4:0]      pre_idx;
  logic [WB-1:0]   pre_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt0, cnt1;
  logic [NR-1:0] exp_g, prev_g;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_wr_data(req_wr_data), .req_wr_en(req_wr_en),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
    .mem_reset(mem_reset), .mem_address(mem_address), .mem_rd_en(mem_rd_en),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (mem_reset) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= mem[mem_address[6:2]];
    for (int b = 0; b < BW; b++) begin
      if (mem_wr_en[b]) mem[mem_address[6:2]][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
    end
    if (pre_we) mem[pre_idx] <= pre_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_address = '0; req_wr_data = '0; req_wr_en = '0;
    pre_we = 1'b1; pre_idx = 5'd4; pre_data = 32'hDEADBEEF;
    next_cycle();
    // reset cycle with both requesters valid: nothing may be accepted
    pre_idx = 5'd8; pre_data = 32'hAAAAAAAA; req_valid = 2'b11;
    #4;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp", 32'(rsp_valid), 32'h0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_addr", 32'(mem_address), 32'h0);
    chk("rst_wdata", mem_wr_data, 32'h0);
    chk("rst_mem_reset", 32'(mem_reset), 32'h1);

    // req 0 reads 0x10
    next_cycle();
    pre_we = 1'b0; reset = 1'b0; req_valid = 2'b01; req_address[6:0] = 7'h10;
    #4;
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_rd_en", 32'(mem_rd_en), 32'h1);
    chk("rd_addr", 32'(mem_address), 32'h10);
    chk("rd_mem_reset", 32'(mem_reset), 32'h0);
    next_cycle();
    req_valid = 2'b00;
    #4;
    chk("rd_rsp", 32'(rsp_valid), 32'h1);
    chk("rd_data", rsp_rd_data, 32'hDEADBEEF);
    chk("idle_ready", 32'(req_ready), 32'h0);
    chk("idle_addr", 32'(mem_address), 32'h0);

    // req 1 partial write 0x20, then read back
    next_cycle();
    req_valid = 2'b10; req_address[13:7] = 7'h20; req_wr_data[63:32] = 32'h12345678; req_wr_en[7:4] = 4'b0011;
    #4;
    chk("wr_ready", 32'(req_ready), 32'h2);
    chk("wr_wr_en", 32'(mem_wr_en), 32'h3);
    chk("wr_rd_en", 32'(mem_rd_en), 32'h0);
    chk("wr_wdata", mem_wr_data, 32'h12345678);
    chk("wr_addr", 32'(mem_address), 32'h20);
    next_cycle();
    req_wr_en[7:4] = 4'b0000;
    #4;
    chk("wr_ack", 32'(rsp_valid), 32'h2);
    chk("rb_ready", 32'(req_ready), 32'h2);
    chk("rb_rd_en", 32'(mem_rd_en), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    #4;
    chk("rb_rsp", 32'(rsp_valid), 32'h2);
    chk("rb_data", rsp_rd_data, 32'hAAAA5678);

    // both requesters valid for 8 cycles
    cnt0 = 0; cnt1 = 0; prev_g = 2'b00;
    req_address[6:0] = 7'h10; req_address[13:7] = 7'h20;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      req_valid = 2'b11;
      #4;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("rr_ready", 32'(req_ready), 32'(exp_g));
      chk("rr_rsp", 32'(rsp_valid), 32'(prev_g));
      if (rsp_valid[0]) cnt0++;
      if (rsp_valid[1]) cnt1++;
      prev_g = exp_g;
    end
    next_cycle();
    req_valid = 2'b00;
    #4;
    chk("rr_rsp_last", 32'(rsp_valid), 32'(prev_g));
    if (rsp_valid[0]) cnt0++;
    if (rsp_valid[1]) cnt1++;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    chk("fp_cnt0", 32'(cnt0), 32'd8);
    chk("fp_cnt1", 32'(cnt1), 32'd0);
`else
    chk("rr_cnt0", 32'(cnt0), 32'd4);
    chk("rr_cnt1", 32'(cnt1), 32'd4);
`endif

    // only req 1 for 3 cycles, then both
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      req_valid = 2'b10;
      #4;
      chk("solo1_ready", 32'(req_ready), 32'h2);
    end
    next_cycle();
    req_valid = 2'b11;
    #4;
    chk("wrap_ready0", 32'(req_ready), 32'h1);
    next_cycle();
    #4;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    chk("wrap_ready1", 32'(req_ready), 32'h1);
`else
    chk("wrap_ready1", 32'(req_ready), 32'h2);
`endif

    // req 0 writes 0x30 in T (pointer moves to 1), reset in T+1
    next_cycle();
    req_valid = 2'b01; req_address[6:0] = 7'h30; req_wr_data[31:0] = 32'hCAFEF00D; req_wr_en[3:0] = 4'hF;
    #4;
    chk("pre_rst_ready", 32'(req_ready), 32'h1);
    next_cycle();
    reset = 1'b1; req_valid = 2'b11; req_wr_en[3:0] = 4'h0;
    #4;
    chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_mem_reset", 32'(mem_reset), 32'h1);
    next_cycle();
    reset = 1'b0;
    #4;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    #4;
    chk("post_rst_rsp", 32'(rsp_valid), 32'h1);
    chk("post_rst_data", rsp_rd_data, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
